lane_loader: RTL



---
 rtl/lane_loader.sv | 89 ++++++++
 1 files changed

// File: rtl/lane_loader.sv
// lane_loader: double-buffered stream-to-five-lane loader with atomic frame commit.
// Define LANE_LOADER_FRAME_CNT_EN to add the 8-bit FRAME_CNT commit counter output.
module lane_loader #(
  parameter int WD = 4
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic [WD-1:0] IN_DATA,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic          HOLD,
  output logic [WD-1:0] OUT0,
  output logic [WD-1:0] OUT1,
  output logic [WD-1:0] OUT2,
  output logic [WD-1:0] OUT3,
  output logic [WD-1:0] OUT4,
  output logic          FRAME_VALID,
  output logic          COMMIT
`ifdef LANE_LOADER_FRAME_CNT_EN
  ,
  output logic [7:0]    FRAME_CNT
`endif
);

  localparam int         NLANE     = 5;
  localparam logic [2:0] LAST_LANE = 3'd4;

  logic [WD-1:0] sh  [NLANE];
  logic [WD-1:0] act [NLANE];
  logic [2:0]    wptr;
  logic          sh_full;
  logic          xfer;
  logic          do_commit;

  // A full shadow bank only blocks input while the consumer is frozen.
  assign IN_READY  = !sh_full || !HOLD;
  assign xfer      = IN_VALID && IN_READY;
  assign do_commit = sh_full && !HOLD;

  // Shadow bank fills in lane order; wptr is back at 0 whenever sh_full is set,
  // so a transfer on the commit edge always starts the next frame in lane 0.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      for (int k = 0; k < NLANE; k++) sh[k] <= '0;
      wptr    <= '0;
      sh_full <= 1'b0;
    end else begin
      if (xfer) begin
        for (int k = 0; k < NLANE; k++)
          if (wptr == 3'(k)) sh[k] <= IN_DATA;
        wptr <= (wptr == LAST_LANE) ? 3'd0 : wptr + 3'd1;
      end
      if (xfer && wptr == LAST_LANE)
        sh_full <= 1'b1;
      else if (do_commit)
        sh_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      for (int k = 0; k < NLANE; k++) act[k] <= '0;
      COMMIT      <= 1'b0;
      FRAME_VALID <= 1'b0;
    end else begin
      COMMIT <= do_commit;
      if (do_commit) begin
        for (int k = 0; k < NLANE; k++) act[k] <= sh[k];
        FRAME_VALID <= 1'b1;
      end
    end
  end

  assign OUT0 = act[0];
  assign OUT1 = act[1];
  assign OUT2 = act[2];
  assign OUT3 = act[3];
  assign OUT4 = act[4];

`ifdef LANE_LOADER_FRAME_CNT_EN
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X)
      FRAME_CNT <= 8'd0;
    else if (do_commit)
      FRAME_CNT <= FRAME_CNT + 8'd1;
  end
`endif

endmodule
